// File: rtl/mult_wb_buffer.sv
// Two-entry writeback FIFO between the multiplier and the register-file write port.
// It also forwards results that are not yet written back and counts writeback stall cycles.
module mult_wb_buffer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mult_valid_i,
    input  logic              mult_multicycle_i,
    input  logic [DATA_W-1:0] mult_result_i,
    input  logic [ADDR_W-1:0] mult_waddr_i,
    output logic              ex_ready_o,
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [ADDR_W-1:0] wb_waddr_o,
    output logic [DATA_W-1:0] wb_wdata_o,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] fwd_addr_i,
    output logic              fwd_hit_o,
    output logic [DATA_W-1:0] fwd_data_o,
    output logic [1:0]        count_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic [DATA_W-1:0] data_q [2];
    logic [DATA_W-1:0] data_d [2];
    logic [ADDR_W-1:0] addr_q [2];
    logic [ADDR_W-1:0] addr_d [2];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              push, pop;
    logic              young;

    assign ex_ready_o  = (count_q != 2'd2) & ~flush_i;
    assign wb_valid_o  = (count_q != 2'd0);
    assign wb_waddr_o  = addr_q[rd_ptr_q];
    assign wb_wdata_o  = data_q[rd_ptr_q];
    assign count_o     = count_q;
    assign stall_cnt_o = stall_q;

    // MULH partials arrive with multicycle set and must never enter the FIFO.
    assign push  = mult_valid_i & ~mult_multicycle_i & ex_ready_o;
    assign pop   = wb_valid_o & wb_ready_i & ~flush_i;
    assign young = ~wr_ptr_q;

    always_comb begin
        data_d   = data_q;
        addr_d   = addr_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        stall_d  = stall_q;
        if (wb_valid_o && !wb_ready_i && stall_q != '1) begin
            stall_d = stall_q + 1'b1;
        end
        if (flush_i) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                data_d[wr_ptr_q] = mult_result_i;
                addr_d[wr_ptr_q] = mult_waddr_i;
                wr_ptr_d         = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            if (push && !pop) begin
                count_d = count_q + 2'd1;
            end else if (pop && !push) begin
                count_d = count_q - 2'd1;
            end
        end
    end

    // Youngest entry (wr_ptr-1) is checked last so it wins over the head.
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        if (fwd_addr_i != '0 && count_q != 2'd0) begin
            if (addr_q[rd_ptr_q] == fwd_addr_i) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = data_q[rd_ptr_q];
            end
            if (addr_q[young] == fwd_addr_i) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = data_q[young];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            addr_q[0] <= '0;
            addr_q[1] <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            stall_q   <= '0;
        end else begin
            data_q    <= data_d;
            addr_q    <= addr_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            stall_q   <= stall_d;
        end
    end

endmodule

// File: tb/tb_mult_wb_buffer.sv
// Directed bench for mult_wb_buffer: each task drives one scenario and checks hand-computed values.
module tb_mult_wb_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        mult_valid_i, mult_multicycle_i;
    logic [31:0] mult_result_i;
    logic [5:0]  mult_waddr_i;
    logic        ex_ready_o, wb_valid_o, wb_ready_i, flush_i, fwd_hit_o;
    logic [5:0]  wb_waddr_o, fwd_addr_i;
    logic [31:0] wb_wdata_o, fwd_data_o;
    logic [1:0]  count_o;
    logic [15:0] stall_cnt_o;

    int checks = 0;
    int errors = 0;

    mult_wb_buffer dut (
        .clk(clk), .rst(rst),
        .mult_valid_i(mult_valid_i), .mult_multicycle_i(mult_multicycle_i),
        .mult_result_i(mult_result_i), .mult_waddr_i(mult_waddr_i),
        .ex_ready_o(ex_ready_o), .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_waddr_o(wb_waddr_o), .wb_wdata_o(wb_wdata_o), .flush_i(flush_i),
        .fwd_addr_i(fwd_addr_i), .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o),
        .count_o(count_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic mc, input logic [31:0] d, input logic [5:0] a);
        mult_valid_i      = v;
        mult_multicycle_i = mc;
        mult_result_i     = d;
        mult_waddr_i      = a;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (wb_valid_o !== 1'b0 || ex_ready_o !== 1'b1 || count_o !== 2'd0 ||
            stall_cnt_o !== 16'd0 || fwd_hit_o !== 1'b0 || wb_wdata_o !== 32'd0 || wb_waddr_o !== 6'd0) begin
            errors++;
            $display("FAIL reset: valid=%b ready=%b count=%0d stall=%0d hit=%b data=%h addr=%0d, want 0 1 0 0 0 0 0",
                     wb_valid_o, ex_ready_o, count_o, stall_cnt_o, fwd_hit_o, wb_wdata_o, wb_waddr_o);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_push();
        wb_ready_i = 1'b1;
        drive(1'b1, 1'b0, 32'h64, 6'd5);
        step();
        drive(1'b0, 1'b0, 32'h0, 6'd0);
        checks++;
        if (wb_valid_o !== 1'b1 || wb_waddr_o !== 6'd5 || wb_wdata_o !== 32'h64) begin
            errors++;
            $display("FAIL single_push_head: valid=%b addr=%0d data=%h, want 1 5 00000064", wb_valid_o, wb_waddr_o, wb_wdata_o);
        end
        step();
        checks++;
        if (count_o !== 2'd0 || wb_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_push_drain: count=%0d valid=%b, want 0 0", count_o, wb_valid_o);
        end
    endtask

    task automatic test_backpressure();
        wb_ready_i = 1'b0;
        drive(1'b1, 1'b0, 32'hA, 6'd1);
        step();
        drive(1'b1, 1'b0, 32'hB, 6'd2);
        step();
        drive(1'b0, 1'b0, 32'h0, 6'd0);
        checks++;
        if (count_o !== 2'd2 || ex_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_full: count=%0d ex_ready=%b, want 2 0", count_o, ex_ready_o);
        end
        for (int i = 1; i <= 3; i++) begin
            checks++;
            if (stall_cnt_o !== 16'(i)) begin
                errors++;
                $display("FAIL bp_stall_cnt: got %0d want %0d", stall_cnt_o, i);
            end
            if (i < 3) step();
        end
        wb_ready_i = 1'b1;
        #1;
        checks++;
        if (wb_waddr_o !== 6'd1 || wb_wdata_o !== 32'hA) begin
            errors++;
            $display("FAIL bp_first: addr=%0d data=%h, want 1 0000000a", wb_waddr_o, wb_wdata_o);
        end
        step();
        checks++;
        if (wb_waddr_o !== 6'd2 || wb_wdata_o !== 32'hB || ex_ready_o !== 1'b1 || count_o !== 2'd1) begin
            errors++;
            $display("FAIL bp_second: addr=%0d data=%h ex_ready=%b count=%0d, want 2 0000000b 1 1",
                     wb_waddr_o, wb_wdata_o, ex_ready_o, count_o);
        end
        step();
        checks++;
        if (count_o !== 2'd0 || stall_cnt_o !== 16'd3) begin
            errors++;
            $display("FAIL bp_drain: count=%0d stall=%0d, want 0 3", count_o, stall_cnt_o);
        end
    endtask

    task automatic test_mulh();
        wb_ready_i = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b1, 32'(i), 6'd7);
            step();
        end
        checks++;
        if (count_o !== 2'd0) begin
            errors++;
            $display("FAIL mulh_partials: count=%0d want 0", count_o);
        end
        drive(1'b1, 1'b0, 32'hFFFF_FFFE, 6'd7);
        step();
        drive(1'b0, 1'b0, 32'h0, 6'd0);
        checks++;
        if (count_o !== 2'd1 || wb_waddr_o !== 6'd7 || wb_wdata_o !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL mulh_final: count=%0d addr=%0d data=%h, want 1 7 fffffffe", count_o, wb_waddr_o, wb_wdata_o);
        end
        wb_ready_i = 1'b1;
        step();
        checks++;
        if (count_o !== 2'd0) begin
            errors++;
            $display("FAIL mulh_drain: count=%0d want 0", count_o);
        end
    endtask

    task automatic test_forward();
        wb_ready_i = 1'b0;
        drive(1'b1, 1'b0, 32'h11, 6'd3);
        step();
        drive(1'b1, 1'b0, 32'h22, 6'd3);
        fwd_addr_i = 6'd3;
        #1;
        checks++;
        if (fwd_hit_o !== 1'b1 || fwd_data_o !== 32'h11) begin
            errors++;
            $display("FAIL fwd_no_push_bypass: hit=%b data=%h, want 1 00000011", fwd_hit_o, fwd_data_o);
        end
        step();
        drive(1'b0, 1'b0, 32'h0, 6'd0);
        #1;
        checks++;
        if (fwd_hit_o !== 1'b1 || fwd_data_o !== 32'h22) begin
            errors++;
            $display("FAIL fwd_youngest: hit=%b data=%h, want 1 00000022", fwd_hit_o, fwd_data_o);
        end
        fwd_addr_i = 6'd4;
        #1;
        checks++;
        if (fwd_hit_o !== 1'b0) begin
            errors++;
            $display("FAIL fwd_miss: hit=%b want 0", fwd_hit_o);
        end
    endtask

    task automatic test_flush();
        flush_i = 1'b1;
        drive(1'b1, 1'b0, 32'h99, 6'd9);
        #1;
        checks++;
        if (ex_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_ex_ready: got %b want 0", ex_ready_o);
        end
        step();
        flush_i = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 6'd0);
        checks++;
        if (count_o !== 2'd0 || wb_valid_o !== 1'b0 || stall_cnt_o !== 16'd5) begin
            errors++;
            $display("FAIL flush_state: count=%0d valid=%b stall=%0d, want 0 0 5", count_o, wb_valid_o, stall_cnt_o);
        end
        step();
        checks++;
        if (count_o !== 2'd0) begin
            errors++;
            $display("FAIL flush_no_entry: count=%0d want 0", count_o);
        end
    endtask

    task automatic test_back_to_back();
        wb_ready_i = 1'b1;
        fwd_addr_i = 6'd0;
        drive(1'b1, 1'b0, 32'h1010, 6'd10);
        step();
        drive(1'b1, 1'b0, 32'h1111, 6'd11);
        step();
        drive(1'b0, 1'b0, 32'h0, 6'd0);
        checks++;
        if (count_o !== 2'd1 || wb_waddr_o !== 6'd11 || wb_wdata_o !== 32'h1111) begin
            errors++;
            $display("FAIL b2b_pushpop: count=%0d addr=%0d data=%h, want 1 11 00001111", count_o, wb_waddr_o, wb_wdata_o);
        end
        step();
        checks++;
        if (count_o !== 2'd0) begin
            errors++;
            $display("FAIL b2b_drain: count=%0d want 0", count_o);
        end
    endtask

    task automatic test_x0_forward();
        wb_ready_i = 1'b0;
        drive(1'b1, 1'b0, 32'h77, 6'd0);
        step();
        drive(1'b0, 1'b0, 32'h0, 6'd0);
        fwd_addr_i = 6'd0;
        #1;
        checks++;
        if (fwd_hit_o !== 1'b0 || wb_valid_o !== 1'b1 || wb_wdata_o !== 32'h77) begin
            errors++;
            $display("FAIL x0_forward: hit=%b valid=%b data=%h, want 0 1 00000077", fwd_hit_o, wb_valid_o, wb_wdata_o);
        end
        wb_ready_i = 1'b1;
        step();
    endtask

    task automatic test_async_reset();
        wb_ready_i = 1'b0;
        drive(1'b1, 1'b0, 32'h55, 6'd12);
        step();
        drive(1'b0, 1'b0, 32'h0, 6'd0);
        checks++;
        if (count_o !== 2'd1 || stall_cnt_o !== 16'd5) begin
            errors++;
            $display("FAIL areset_pre: count=%0d stall=%0d, want 1 5", count_o, stall_cnt_o);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (wb_valid_o !== 1'b0 || ex_ready_o !== 1'b1 || stall_cnt_o !== 16'd0 || count_o !== 2'd0) begin
            errors++;
            $display("FAIL areset_now: valid=%b ex_ready=%b stall=%0d count=%0d, want 0 1 0 0",
                     wb_valid_o, ex_ready_o, stall_cnt_o, count_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        wb_ready_i = 1'b0;
        flush_i = 1'b0;
        fwd_addr_i = 6'd0;
        drive(1'b0, 1'b0, 32'h0, 6'd0);
        test_reset();
        test_single_push();
        test_backpressure();
        test_mulh();
        test_forward();
        test_flush();
        test_back_to_back();
        test_x0_forward();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
